chunk_pingpong_ctrl: RTL and testbench

CHUNK_PINGPONG_CTRL -- requirements
Module: chunk_pingpong_ctrl

---
 rtl/chunk_pingpong_ctrl.sv | 168 ++++++++++++++++
 tb/tb_chunk_pingpong_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// chunk_pingpong_ctrl
//   Ping-pong controller for two Data_Chunk banks. Upstream beats are written
//   into the bank selected by fill_ptr; each completed chunk of BEAT_NUM
//   beats is handed to compute in order (cmp_ptr). Compute releases its bank
//   with cmp_done_i, which frees it for refilling.
//
//   Bank states:
//     state     | meaning
//     EMPTY     | free, next beat may start a new chunk here
//     FILLING   | chunk partially written
//     FULL      | chunk complete, waiting for compute
//     COMPUTING | owned by compute until cmp_done_i
//
// Ports
//   clk_i, rst_ni           clock, async active-low reset
//   flush_i                 synchronous clear of all bank state
//   in_valid_i/in_ready_o   upstream beat handshake
//   in_sparsemap_i          beat sparsemap (BUS_SIZE bits)
//   in_nonzero_data_i       beat nonzero bytes (BUS_SIZE*8 bits)
//   wr_valid_o              one-hot write strobe to bank 0/1
//   wr_count_o              beat index within chunk
//   wr_sparsemap_o          sparsemap to both banks
//   wr_nonzero_data_o       data to both banks
//   cmp_start_o/cmp_bank_o  one-cycle start pulse and bank owned by compute
//   cmp_done_i              compute finished with cmp_bank_o
//   bank_full_o             per-bank FULL or COMPUTING
//   chunk_cnt_o             completed-chunk counter (wraps)
// ---------------------------------------------------------------------------
module chunk_pingpong_ctrl #(
    parameter int BUS_SIZE = 128,
    parameter int BEAT_NUM = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [BUS_SIZE-1:0]         in_sparsemap_i,
    input  logic [BUS_SIZE*8-1:0]       in_nonzero_data_i,
    output logic [1:0]                  wr_valid_o,
    output logic [$clog2(BEAT_NUM)-1:0] wr_count_o,
    output logic [BUS_SIZE-1:0]         wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0]       wr_nonzero_data_o,
    output logic                        cmp_start_o,
    output logic                        cmp_bank_o,
    input  logic                        cmp_done_i,
    output logic [1:0]                  bank_full_o,
    output logic [15:0]                 chunk_cnt_o
);

    localparam int CW = $clog2(BEAT_NUM);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FILLING   = 2'd1,
        FULL      = 2'd2,
        COMPUTING = 2'd3
    } bank_st_t;

    bank_st_t          r_bank [2];
    logic              r_fill_ptr;
    logic              r_cmp_ptr;
    logic [CW-1:0]     r_beat_cnt;
    logic [15:0]       r_chunk_cnt;
    logic              r_cmp_start;
    logic              r_cmp_bank;

    bank_st_t          w_bank_nxt [2];
    logic              w_fill_nxt;
    logic              w_cmp_ptr_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [15:0]       w_chunk_nxt;
    logic              w_start_nxt;
    logic              w_cmp_bank_nxt;
    logic              w_hs;
    logic              w_last;
    logic              w_computing;

    assign in_ready_o = ((r_bank[r_fill_ptr] == EMPTY) || (r_bank[r_fill_ptr] == FILLING))
                        && !flush_i;
    assign w_hs       = in_valid_i && in_ready_o;
    assign w_last     = (r_beat_cnt == CW'(BEAT_NUM - 1));
    assign w_computing = (r_bank[0] == COMPUTING) || (r_bank[1] == COMPUTING);

    assign wr_valid_o        = w_hs ? (r_fill_ptr ? 2'b10 : 2'b01) : 2'b00;
    assign wr_count_o        = r_beat_cnt;
    assign wr_sparsemap_o    = in_sparsemap_i;
    assign wr_nonzero_data_o = in_nonzero_data_i;

    assign cmp_start_o = r_cmp_start;
    assign cmp_bank_o  = r_cmp_bank;
    assign chunk_cnt_o = r_chunk_cnt;
    assign bank_full_o = {(r_bank[1] == FULL) || (r_bank[1] == COMPUTING),
                          (r_bank[0] == FULL) || (r_bank[0] == COMPUTING)};

    // Fill and release updates are applied first; the start decision then
    // looks at the resulting bank states so a bank completed (or freed) this
    // cycle can be handed to compute on the same edge.
    always_comb begin
        w_bank_nxt[0]  = r_bank[0];
        w_bank_nxt[1]  = r_bank[1];
        w_fill_nxt     = r_fill_ptr;
        w_cmp_ptr_nxt  = r_cmp_ptr;
        w_cnt_nxt      = r_beat_cnt;
        w_chunk_nxt    = r_chunk_cnt;
        w_start_nxt    = 1'b0;
        w_cmp_bank_nxt = r_cmp_bank;

        if (w_hs) begin
            if (w_last) begin
                w_bank_nxt[r_fill_ptr] = FULL;
                w_cnt_nxt              = '0;
                w_fill_nxt             = ~r_fill_ptr;
                w_chunk_nxt            = r_chunk_cnt + 16'd1;
            end else begin
                w_bank_nxt[r_fill_ptr] = FILLING;
                w_cnt_nxt              = r_beat_cnt + CW'(1);
            end
        end

        if (cmp_done_i && w_computing) begin
            w_bank_nxt[r_cmp_bank] = EMPTY;
            w_cmp_ptr_nxt          = ~r_cmp_ptr;
        end

        if ((w_bank_nxt[0] != COMPUTING) && (w_bank_nxt[1] != COMPUTING)
            && (w_bank_nxt[w_cmp_ptr_nxt] == FULL)) begin
            w_start_nxt                = 1'b1;
            w_cmp_bank_nxt             = w_cmp_ptr_nxt;
            w_bank_nxt[w_cmp_ptr_nxt]  = COMPUTING;
        end

        if (flush_i) begin
            w_bank_nxt[0]  = EMPTY;
            w_bank_nxt[1]  = EMPTY;
            w_fill_nxt     = 1'b0;
            w_cmp_ptr_nxt  = 1'b0;
            w_cnt_nxt      = '0;
            w_chunk_nxt    = r_chunk_cnt;
            w_start_nxt    = 1'b0;
            w_cmp_bank_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bank[0]   <= EMPTY;
            r_bank[1]   <= EMPTY;
            r_fill_ptr  <= 1'b0;
            r_cmp_ptr   <= 1'b0;
            r_beat_cnt  <= '0;
            r_chunk_cnt <= 16'd0;
            r_cmp_start <= 1'b0;
            r_cmp_bank  <= 1'b0;
        end else begin
            r_bank[0]   <= w_bank_nxt[0];
            r_bank[1]   <= w_bank_nxt[1];
            r_fill_ptr  <= w_fill_nxt;
            r_cmp_ptr   <= w_cmp_ptr_nxt;
            r_beat_cnt  <= w_cnt_nxt;
            r_chunk_cnt <= w_chunk_nxt;
            r_cmp_start <= w_start_nxt;
            r_cmp_bank  <= w_cmp_bank_nxt;
        end
    end

endmodule

// File: tb/tb_chunk_pingpong_ctrl.sv
module tb_chunk_pingpong_ctrl;

    localparam int BS = 16;
    localparam int BN = 8;
    localparam int CW = $clog2(BN);

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [BS-1:0]     in_sparsemap_i = '0;
    logic [BS*8-1:0]   in_nonzero_data_i = '0;
    logic [1:0]        wr_valid_o;
    logic [CW-1:0]     wr_count_o;
    logic [BS-1:0]     wr_sparsemap_o;
    logic [BS*8-1:0]   wr_nonzero_data_o;
    logic              cmp_start_o;
    logic              cmp_bank_o;
    logic              cmp_done_i = 1'b0;
    logic [1:0]        bank_full_o;
    logic [15:0]       chunk_cnt_o;

    chunk_pingpong_ctrl #(.BUS_SIZE(BS), .BEAT_NUM(BN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_sparsemap_i(in_sparsemap_i), .in_nonzero_data_i(in_nonzero_data_i),
        .wr_valid_o(wr_valid_o), .wr_count_o(wr_count_o),
        .wr_sparsemap_o(wr_sparsemap_o), .wr_nonzero_data_o(wr_nonzero_data_o),
        .cmp_start_o(cmp_start_o), .cmp_bank_o(cmp_bank_o), .cmp_done_i(cmp_done_i),
        .bank_full_o(bank_full_o), .chunk_cnt_o(chunk_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]    v;
        logic [CW-1:0] c;
        logic [BS-1:0] sm;
        logic [BS*8-1:0] d;
    } wr_t;

    wr_t  wr_q[$];
    logic cmp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents a write or a start.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (wr_valid_o != 2'b00) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL wr_unexpected: got wr_valid=%b expected none", wr_valid_o);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_valid", 32'(wr_valid_o), 32'(e.v));
                    check("wr_count", 32'(wr_count_o), 32'(e.c));
                    check("wr_sparsemap", 32'(wr_sparsemap_o), 32'(e.sm));
                    check("wr_data_eq", 32'(wr_nonzero_data_o == e.d), 32'd1);
                end
            end
            if (cmp_start_o) begin
                if (cmp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL cmp_unexpected: got cmp_start bank %0d expected none", cmp_bank_o);
                end else begin
                    check("cmp_bank", 32'(cmp_bank_o), 32'(cmp_q.pop_front()));
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk_i); #1;
    endtask

    task automatic send(input logic b, input int c, input logic done);
        wr_t e;
        bit  ok;
        e.v  = b ? 2'b10 : 2'b01;
        e.c  = CW'(c);
        e.sm = BS'($urandom);
        e.d  = {$urandom, $urandom, $urandom, $urandom};
        wr_q.push_back(e);
        in_sparsemap_i    = e.sm;
        in_nonzero_data_i = e.d;
        in_valid_i        = 1'b1;
        cmp_done_i        = done;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (in_ready_o) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 (bank %0d count %0d)", b, c);
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        cmp_done_i = 1'b0;
    endtask

    task automatic done_pulse();
        cmp_done_i = 1'b1;
        sync();
        cmp_done_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_wr_count", 32'(wr_count_o), 0);
        check("rst_bank_full", 32'(bank_full_o), 0);
        check("rst_chunk_cnt", 32'(chunk_cnt_o), 0);
        sync();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_ready", 32'(in_ready_o), 1);
        check("rst_cmp_start", 32'(cmp_start_o), 0);
        check("rst_cmp_bank", 32'(cmp_bank_o), 0);
        check("rst_wr_valid", 32'(wr_valid_o), 0);
        sync();

        // single chunk into bank 0
        for (int i = 0; i < BN; i++) begin
            if (i == BN - 1) cmp_q.push_back(1'b0);
            send(1'b0, i, 1'b0);
        end
        @(negedge clk_i);
        check("c1_start", 32'(cmp_start_o), 1);
        check("c1_chunk_cnt", 32'(chunk_cnt_o), 1);
        check("c1_bank_full", 32'(bank_full_o), 32'b01);
        @(negedge clk_i);
        check("c1_start_pulse", 32'(cmp_start_o), 0);
        sync();

        // bank 1 filled while bank 0 computes
        for (int i = 0; i < BN; i++) send(1'b1, i, 1'b0);
        @(negedge clk_i);
        check("pp_ready", 32'(in_ready_o), 0);
        check("pp_bank_full", 32'(bank_full_o), 32'b11);
        check("pp_chunk_cnt", 32'(chunk_cnt_o), 2);
        sync();

        // release bank 0 -> start bank 1, refill bank 0
        cmp_q.push_back(1'b1);
        done_pulse();
        @(negedge clk_i);
        check("rel_start", 32'(cmp_start_o), 1);
        check("rel_ready", 32'(in_ready_o), 1);
        check("rel_bank_full", 32'(bank_full_o), 32'b10);
        sync();

        for (int i = 0; i < BN; i++) send(1'b0, i, 1'b0);
        @(negedge clk_i);
        check("full2_ready", 32'(in_ready_o), 0);
        check("full2_bank_full", 32'(bank_full_o), 32'b11);
        sync();
        cmp_q.push_back(1'b0);
        done_pulse();
        @(negedge clk_i);
        check("rel2_start", 32'(cmp_start_o), 1);
        check("rel2_bank_full", 32'(bank_full_o), 32'b01);
        sync();

        // collision: last beat of bank 1 with cmp_done for bank 0
        for (int i = 0; i < BN - 1; i++) send(1'b1, i, 1'b0);
        cmp_q.push_back(1'b1);
        send(1'b1, BN - 1, 1'b1);
        @(negedge clk_i);
        check("col_bank_full", 32'(bank_full_o), 32'b10);
        check("col_start", 32'(cmp_start_o), 1);
        check("col_chunk_cnt", 32'(chunk_cnt_o), 4);
        check("col_ready", 32'(in_ready_o), 1);
        sync();

        // free bank 1, then a stray cmp_done
        done_pulse();
        @(negedge clk_i);
        check("free_bank_full", 32'(bank_full_o), 0);
        sync();
        done_pulse();
        @(negedge clk_i);
        check("stray_bank_full", 32'(bank_full_o), 0);
        check("stray_ready", 32'(in_ready_o), 1);
        check("stray_count", 32'(wr_count_o), 0);
        check("stray_chunk_cnt", 32'(chunk_cnt_o), 4);
        sync();

        // backpressure: valid every other cycle, fill_ptr is back at bank 0
        for (int i = 0; i < 4; i++) begin
            send(1'b0, i, 1'b0);
            @(negedge clk_i);
            check("bp_count_hold", 32'(wr_count_o), 32'(i + 1));
            sync();
        end

        // reset mid-chunk
        rst_ni = 1'b0;
        #2;
        check("mr_wr_count", 32'(wr_count_o), 0);
        check("mr_bank_full", 32'(bank_full_o), 0);
        check("mr_chunk_cnt", 32'(chunk_cnt_o), 0);
        check("mr_cmp_start", 32'(cmp_start_o), 0);
        check("mr_cmp_bank", 32'(cmp_bank_o), 0);
        check("mr_wr_valid", 32'(wr_valid_o), 0);
        sync();
        sync();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("mr_ready", 32'(in_ready_o), 1);
        check("mr_count_after", 32'(wr_count_o), 0);
        sync();

        // flush mid-chunk of bank 1
        for (int i = 0; i < BN; i++) begin
            if (i == BN - 1) cmp_q.push_back(1'b0);
            send(1'b0, i, 1'b0);
        end
        for (int i = 0; i < 6; i++) send(1'b1, i, 1'b0);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        @(negedge clk_i);
        check("fl_ready", 32'(in_ready_o), 0);
        check("fl_wr_valid", 32'(wr_valid_o), 0);
        sync();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("fl_bank_full", 32'(bank_full_o), 0);
        check("fl_chunk_cnt", 32'(chunk_cnt_o), 1);
        check("fl_count", 32'(wr_count_o), 0);
        sync();
        send(1'b0, 0, 1'b0);
        @(negedge clk_i);
        check("fl_chunk_after", 32'(chunk_cnt_o), 1);

        repeat (3) sync();
        check("wr_q_drained", 32'(wr_q.size()), 0);
        check("cmp_q_drained", 32'(cmp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
